// File: rtl/two_opt_scheduler.sv
// two_opt_scheduler: walks a closed tour of N_CITY cities in windows of four
// consecutive positions, drives one external adjacent-swap checker per window,
// and swaps the two middle positions whenever the checker reports a gain.
// Passes repeat until a pass applies no swap or MAX_PASS passes have run.
// Optional feature: define SWAP_TRACE_EN to add the swap_valid/swap_pos/swap_gain
// trace outputs.
module two_opt_scheduler #(
    parameter int N_CITY   = 16,
    parameter int IDX_W    = 4,
    parameter int MAX_PASS = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [7:0]       wr_x,
    input  logic [7:0]       wr_y,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [7:0]       pass_cnt,
    output logic [31:0]      total_gain,
    input  logic [IDX_W-1:0] rd_pos,
    output logic [IDX_W-1:0] rd_city,
    output logic             chk_rst,
    output logic [7:0]       chk_x1,
    output logic [7:0]       chk_y1,
    output logic [7:0]       chk_x2,
    output logic [7:0]       chk_y2,
    output logic [7:0]       chk_x3,
    output logic [7:0]       chk_y3,
    output logic [7:0]       chk_x4,
    output logic [7:0]       chk_y4,
`ifdef SWAP_TRACE_EN
    output logic             swap_valid,
    output logic [IDX_W-1:0] swap_pos,
    output logic [31:0]      swap_gain,
`endif
    input  logic             chk_res,
    input  logic             chk_complete,
    input  logic [31:0]      chk_diff
);

    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_LOAD, S_KICK, S_WAIT, S_APPLY, S_END_PASS, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] p_q, p_d;
    logic             swap_q, swap_d;
    logic [7:0]       pass_q, pass_d;
    logic [31:0]      gain_q, gain_d;
    logic [7:0]       cx_q [4];
    logic [7:0]       cx_d [4];
    logic [7:0]       cy_q [4];
    logic [7:0]       cy_d [4];
    logic [IDX_W-1:0] tour_q [DEPTH];
    logic [IDX_W-1:0] tour_d [DEPTH];
    logic [7:0]       xmem [DEPTH];
    logic [7:0]       ymem [DEPTH];
    logic [IDX_W-1:0] p1, p2;

    // Tour position p+k wrapped modulo N_CITY.
    function automatic logic [IDX_W-1:0] pos_add(input logic [IDX_W-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= 32'(N_CITY)) s = s - 32'(N_CITY);
        return IDX_W'(s);
    endfunction

    assign p1 = pos_add(p_q, 1);
    assign p2 = pos_add(p_q, 2);

    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign chk_rst    = !((state_q == S_KICK) || (state_q == S_WAIT));
    assign pass_cnt   = pass_q;
    assign total_gain = gain_q;
    assign rd_city    = tour_q[rd_pos];
    assign chk_x1 = cx_q[0];
    assign chk_y1 = cy_q[0];
    assign chk_x2 = cx_q[1];
    assign chk_y2 = cy_q[1];
    assign chk_x3 = cx_q[2];
    assign chk_y3 = cy_q[2];
    assign chk_x4 = cx_q[3];
    assign chk_y4 = cy_q[3];

`ifdef SWAP_TRACE_EN
    assign swap_valid = (state_q == S_APPLY) && chk_res;
    assign swap_pos   = swap_valid ? p1 : '0;
    assign swap_gain  = swap_valid ? chk_diff : '0;
`endif

    // Coordinate RAM: host writes accepted only while idle; no reset.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            xmem[wr_addr] <= wr_x;
            ymem[wr_addr] <= wr_y;
        end
    end

    // State and datapath registers; reset restores the identity tour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            swap_q  <= 1'b0;
            pass_q  <= '0;
            gain_q  <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                cx_q[k] <= '0;
                cy_q[k] <= '0;
            end
            for (int unsigned k = 0; k < DEPTH; k++) tour_q[k] <= IDX_W'(k);
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            swap_q  <= swap_d;
            pass_q  <= pass_d;
            gain_q  <= gain_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            tour_q  <= tour_d;
        end
    end

    // Next-state and datapath updates for the window/pass sequencer.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        swap_d  = swap_q;
        pass_d  = pass_q;
        gain_d  = gain_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        tour_d  = tour_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_INIT;
            S_INIT: begin
                p_d     = '0;
                swap_d  = 1'b0;
                pass_d  = '0;
                gain_d  = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                for (int unsigned k = 0; k < 4; k++) begin
                    cx_d[k] = xmem[tour_q[pos_add(p_q, k)]];
                    cy_d[k] = ymem[tour_q[pos_add(p_q, k)]];
                end
                state_d = S_KICK;
            end
            S_KICK: state_d = S_WAIT;
            S_WAIT: if (chk_complete) state_d = S_APPLY;
            S_APPLY: begin
                if (chk_res) begin
                    tour_d[p1] = tour_q[p2];
                    tour_d[p2] = tour_q[p1];
                    gain_d     = gain_q + chk_diff;
                    swap_d     = 1'b1;
                end
                if (32'(p_q) == 32'(N_CITY - 1)) begin
                    state_d = S_END_PASS;
                end else begin
                    p_d     = p_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_END_PASS: begin
                pass_d = pass_q + 8'd1;
                if (!swap_q || (pass_d == 8'(MAX_PASS))) begin
                    state_d = S_DONE;
                end else begin
                    p_d     = '0;
                    swap_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule
